// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 3-sample majority vote per bit,
// one-cycle rx_done / frame_err strobes.
`timescale 1ns/1ps
module uart_byte_rx #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [2:0] baud_set,
   input  logic       uart_rx,
   output logic [7:0] Data,
   output logic       rx_done,
   output logic       frame_err
);

   localparam int unsigned DIV0 = CLK_FREQ / (9600 * 16) - 1;
   localparam int unsigned DIV1 = CLK_FREQ / (19200 * 16) - 1;
   localparam int unsigned DIV2 = CLK_FREQ / (38400 * 16) - 1;
   localparam int unsigned DIV3 = CLK_FREQ / (57600 * 16) - 1;
   localparam int unsigned DIV4 = CLK_FREQ / (115200 * 16) - 1;
   localparam int DW = (DIV0 > 0) ? $clog2(DIV0 + 1) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q;
   logic            rx_s1_q, rx_s2_q, rx_s3_q;
   logic [DW-1:0]   div_q, div_cnt_q;
   logic [3:0]      tick_cnt_q;
   logic [2:0]      bit_idx_q;
   logic [1:0]      smp_q;
   logic [7:0]      shift_q, data_q;
   logic            rx_done_q, frame_err_q;

   logic [DW-1:0]   div_d;
   logic            fall_d, tick_d, maj_d;

   always_comb begin
      div_d = DW'(DIV4);
      case (baud_set)
         3'd0:    div_d = DW'(DIV0);
         3'd1:    div_d = DW'(DIV1);
         3'd2:    div_d = DW'(DIV2);
         3'd3:    div_d = DW'(DIV3);
         default: div_d = DW'(DIV4);
      endcase
   end

   assign fall_d = rx_s3_q & ~rx_s2_q;
   assign tick_d = (state_q != IDLE) && (div_cnt_q == div_q);
   // Third vote is the live synchronised sample at tick 8.
   assign maj_d  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s2_q) | (smp_q[1] & rx_s2_q);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_s3_q     <= 1'b1;
         state_q     <= IDLE;
         div_q       <= '0;
         div_cnt_q   <= '0;
         tick_cnt_q  <= '0;
         bit_idx_q   <= '0;
         smp_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_s1_q     <= uart_rx;
         rx_s2_q     <= rx_s1_q;
         rx_s3_q     <= rx_s2_q;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         if (state_q == IDLE) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            if (fall_d) begin
               div_q   <= div_d;
               state_q <= START;
            end
         end else if (!tick_d) begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end else begin
            div_cnt_q  <= '0;
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_cnt_q == 4'd6) smp_q[0] <= rx_s2_q;
            if (tick_cnt_q == 4'd7) smp_q[1] <= rx_s2_q;
            case (state_q)
               START: begin
                  if (tick_cnt_q == 4'd8 && maj_d) state_q <= IDLE;
                  else if (tick_cnt_q == 4'd15)    state_q <= DATA;
               end
               DATA: begin
                  if (tick_cnt_q == 4'd8) shift_q <= {maj_d, shift_q[7:1]};
                  if (tick_cnt_q == 4'd15) begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     if (bit_idx_q == 3'd7) state_q <= STOP;
                  end
               end
               STOP: begin
                  // Leave mid-stop-bit so a following start edge is not missed.
                  if (tick_cnt_q == 4'd8) begin
                     if (maj_d) begin
                        data_q    <= shift_q;
                        rx_done_q <= 1'b1;
                     end else begin
                        frame_err_q <= 1'b1;
                     end
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign Data      = data_q;
   assign rx_done   = rx_done_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: drives 8N1 frames and compares strobes/data
// against a frame-level reference model (good stop -> byte, bad stop -> error).
`timescale 1ns/1ps
module tb_uart_byte_rx;

   localparam int BIT4 = 8680;
   localparam int BIT0 = 104167;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [2:0] baud_set;
   logic       uart_rx;
   logic [7:0] Data;
   logic       rx_done, frame_err;

   int   n_tests = 0, n_fail = 0;
   int   obs_q[$];
   int   exp_q[$];
   int   exp_data = 0;
   int   viol = 0;
   logic prev_done = 1'b0, prev_err = 1'b0;
   time  t_strobe = 0;

   uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
      .Clk(Clk), .Reset(Reset), .baud_set(baud_set), .uart_rx(uart_rx),
      .Data(Data), .rx_done(rx_done), .frame_err(frame_err)
   );

   always #10 Clk = ~Clk;

   // Event log: byte value for rx_done, -1 for frame_err.
   always @(negedge Clk) begin
      if (rx_done) begin
         obs_q.push_back(int'(Data));
         t_strobe = $time;
      end
      if (frame_err) obs_q.push_back(-1);
      if ((rx_done && frame_err) || (rx_done && prev_done) || (frame_err && prev_err)) viol++;
      prev_done = rx_done;
      prev_err  = frame_err;
   end

   // Reference model: a frame with a high stop bit yields its byte, a low stop bit an error.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
      uart_rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         #(bit_ns);
      end
      uart_rx = stop;
      #(bit_ns);
      uart_rx = 1'b1;
      if (stop) begin
         exp_q.push_back(int'(b));
         exp_data = int'(b);
      end else begin
         exp_q.push_back(-1);
      end
   endtask

   task automatic clear_logs();
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      Reset = 1'b1; uart_rx = 1'b1; baud_set = 3'd4;
      #201;
      Reset = 1'b0;
      exp_data = 0;
      @(negedge Clk);
      n_tests++;
      if (Data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", Data); end
      n_tests++;
      if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
      n_tests++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      #20000;
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_idle_strobes: got %0d expected 0", obs_q.size()); end
   endtask

   task automatic test_single();
      time t0, lat;
      clear_logs();
      baud_set = 3'd4;
      t0 = $time;
      send_frame(8'hAB, 1'b1, BIT4);
      #1000;
      lat = t_strobe - t0;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_event%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL single_data: got %h expected %h", Data, exp_data); end
      n_tests++;
      if (lat < 9 * BIT4 || lat > 10 * BIT4) begin n_fail++; $display("FAIL single_latency: got %0t expected 9..10 bit times", lat); end
   endtask

   task automatic test_frame_err();
      clear_logs();
      send_frame(8'h3C, 1'b0, BIT4);
      #1000;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ferr_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ferr_event%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected %h", Data, exp_data); end
   endtask

   task automatic test_back_to_back();
      clear_logs();
      send_frame(8'hAB, 1'b1, BIT4);
      send_frame(8'h2E, 1'b1, BIT4);
      #1000;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_event%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", Data, exp_data); end
   endtask

   task automatic test_glitch();
      clear_logs();
      uart_rx = 1'b0;
      #2000;
      uart_rx = 1'b1;
      #20000;
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", obs_q.size()); end
      send_frame(8'h55, 1'b1, BIT4);
      #1000;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL glitch_after_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL glitch_after_event%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_baud_reset();
      logic [7:0] b;
      clear_logs();
      baud_set = 3'd0;
      send_frame(8'h55, 1'b1, BIT0);
      #2000;
      n_tests++;
      if (obs_q.size() != 1 || obs_q[0] !== 32'h55) begin n_fail++; $display("FAIL slow_baud_event: got %0d events expected one 0x55", obs_q.size()); end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL slow_baud_data: got %h expected %h", Data, exp_data); end
      // Partial 0xF0 frame cut by reset during bit 4.
      clear_logs();
      baud_set = 3'd4;
      b = 8'hF0;
      uart_rx = 1'b0;
      #(BIT4);
      for (int i = 0; i < 4; i++) begin
         uart_rx = b[i];
         #(BIT4);
      end
      uart_rx = b[4];
      #(BIT4 / 2);
      uart_rx = 1'b1;
      Reset = 1'b1;
      exp_data = 0;
      #201;
      Reset = 1'b0;
      #20000;
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_strobes: got %0d expected 0", obs_q.size()); end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL midreset_data: got %h expected %h", Data, exp_data); end
      send_frame(8'h81, 1'b1, BIT4);
      #1000;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL postreset_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL postreset_data: got %h expected %h", Data, exp_data); end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       s;
      int         gap;
      clear_logs();
      baud_set = 3'd4;
      for (int k = 0; k < 3; k++) begin
         b   = 8'($urandom_range(0, 255));
         s   = ($urandom_range(0, 3) != 0);
         gap = $urandom_range(0, 3);
         send_frame(b, s, BIT4);
         #(gap * BIT4);
      end
      #1000;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_event%0d: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
      n_tests++;
      if (int'(Data) !== exp_data) begin n_fail++; $display("FAIL rand_data: got %h expected %h", Data, exp_data); end
   endtask

   task automatic test_strobe_shape();
      n_tests++;
      if (viol != 0) begin n_fail++; $display("FAIL strobe_shape: got %0d violations expected 0", viol); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_frame_err();
      test_back_to_back();
      test_glitch();
      test_baud_reset();
      test_random();
      test_strobe_shape();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
UART byte receiver, the receive-side counterpart of uart_byte_tx. Format is 8N1, LSB first, with the same baud_set encoding. Recovers one byte per frame from the asynchronous uart_rx line using 16x oversampling and 3-sample majority voting. Delivers a one-cycle rx_done strobe with the byte, or a frame_err strobe on a bad stop bit.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; all divisor values derive from it.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
baud_set  input  3  0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5-7 select 115200.
uart_rx  input  1  serial line, idle high, asynchronous to Clk.
Data  output  8  last correctly received byte.
rx_done  output  1  one-cycle strobe: Data updated with a valid byte.
frame_err  output  1  one-cycle strobe: stop bit sampled low.

Behaviour:
- Reset values: Data=8'h00, rx_done=0, frame_err=0, state=IDLE, all counters 0, synchroniser flops=1.
- Input path: uart_rx passes through a 2-flop synchroniser, then a 1-flop edge register. Start detection is a 1->0 transition on the synchronised signal.
- Oversample tick: a divisor counter generates a one-Clk pulse every DIV+1 clocks, with DIV = CLK_FREQ/(baud*16) - 1 (integer division).
  - At 50 MHz, DIV is 324, 161, 80, 53, 26 for codes 0-4.
- baud_set timing: latched into the divisor at start detection only. Changes mid-frame have no effect until the next frame.
- Divisor counter: held at 0 in IDLE and restarted at start detection, so tick phase is aligned to the falling edge.
- Each bit period = 16 ticks, numbered 0-15.
  - The synchronised line is sampled at ticks 6, 7 and 8.
  - The bit value is the majority of the 3 samples, evaluated at tick 8.
- States:
  - IDLE: wait for falling edge, then go to START.
  - START: at tick 8, if the majority is 1 (glitch), go to IDLE with no strobe. Otherwise continue; after tick 15, go to DATA with bit index 0.
  - DATA: at tick 8 of each bit, shift the majority into a shift register LSB first. After tick 15 of bit 7, go to STOP.
  - STOP: at tick 8 of the stop bit:
    - majority 1: Data <= shift register, rx_done=1 for exactly one Clk.
    - majority 0: frame_err=1 for exactly one Clk; Data unchanged.
    - In both cases go to IDLE on the same cycle. The second half of the stop bit is not awaited, so a following start edge can be caught early.
- Latency: the strobe fires about 9.5 bit times after the start falling edge, plus 3 Clk of synchroniser/edge delay.
- rx_done and frame_err are never high together and never high for more than one Clk.
- Falling edges seen during START/DATA/STOP are ignored; only IDLE detects starts.
- Line held low indefinitely: one frame_err, then the FSM stays in IDLE until the line returns high and falls again.
- Reset asserted mid-frame: all state returns to reset values immediately. A partially received byte is discarded and no strobe is issued. After release, the next falling edge starts a new frame.

Test Plan:
- Reset check: assert Reset at t=0 for 201 ns with uart_rx=1 -> Data=0x00, rx_done=0, frame_err=0; no strobes over 20 us idle.
- Single byte, baud_set=4: drive 0xAB as 8N1 with 8680 ns bits -> exactly one rx_done pulse about 82.5 us after the start edge; Data=0xAB; frame_err never high.
- Back-to-back frames, baud_set=4: 0xAB immediately followed by 0x2E, no idle gap -> two rx_done pulses, Data=0xAB then 0x2E.
- Glitch rejection: 2 us low pulse on idle line at baud_set=4 -> no rx_done, no frame_err, FSM back in IDLE; a following valid 0x55 frame is received correctly.
- Frame error: send 0xAB, then 0x3C with the stop bit driven low -> frame_err pulses once, rx_done stays 0, Data remains 0xAB.
- Baud and reset: baud_set=0 (104.17 us bits), send 0x55 -> rx_done, Data=0x55. Then assert Reset at bit 4 of a 0xF0 frame and release -> no strobe, Data=0x00; next 0x81 frame -> Data=0x81.
